// File: rtl/field_key_sequencer_pkg.sv
// fks_pkg: shared state encoding, field type codes and varint-type predicate for field_key_sequencer
package fks_pkg;
  typedef enum logic [2:0] {IDLE, VAL_RUN, GAP, KEY_RUN, RESP} state_t;
  localparam logic [4:0] TYPE_INT64 = 5'd3;
  localparam logic [4:0] TYPE_UINT64 = 5'd4;
  localparam logic [4:0] TYPE_INT32 = 5'd5;
  localparam logic [4:0] TYPE_BOOL = 5'd8;
  localparam logic [4:0] TYPE_UINT32 = 5'd13;
  localparam logic [4:0] TYPE_ENUM = 5'd14;
  localparam logic [4:0] TYPE_SINT32 = 5'd17;
  localparam logic [4:0] TYPE_SINT64 = 5'd18;
  localparam logic [4:0] KEY_FIELD_TYPE = TYPE_UINT32;
  localparam logic [2:0] WIRE_VARINT = 3'd0;
  function automatic logic is_varint_type(input logic [4:0] t);
    return t inside {TYPE_INT64, TYPE_UINT64, TYPE_INT32, TYPE_BOOL,
                     TYPE_UINT32, TYPE_ENUM, TYPE_SINT32, TYPE_SINT64};
  endfunction
endpackage

// File: rtl/field_key_sequencer.sv
// field_key_sequencer: drives the varint stage for a field value then its key (req_* in, rsp_* out, vi_* to varint stage)
module field_key_sequencer
  import fks_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [28:0] req_field_num,
  input  logic [4:0]  req_field_type,
  input  logic [63:0] req_value,
  input  logic [63:0] req_dst_addr,
  output logic        rsp_done,
  output logic        rsp_err,
  output logic [4:0]  rsp_bytes,
  output logic [63:0] rsp_next_addr,
  output logic        vi_en,
  output logic [63:0] vi_dst_addr,
  output logic [63:0] vi_value,
  output logic [4:0]  vi_field_type,
  input  logic        vi_done,
  input  logic [3:0]  vi_bytes_written
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state;
  logic [28:0] fn_q;
  logic [63:0] dst_q;
  logic [3:0] nv, nk;
  logic err_q;
  logic [CW-1:0] cnt;
  logic [4:0] sum;
  logic timeout;
  assign sum = 5'(nv) + 5'(nk);
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b0;
      rsp_done <= 1'b0;
      rsp_err <= 1'b0;
      rsp_bytes <= '0;
      rsp_next_addr <= '0;
      vi_en <= 1'b0;
      vi_dst_addr <= '0;
      vi_value <= '0;
      vi_field_type <= '0;
      fn_q <= '0;
      dst_q <= '0;
      nv <= '0;
      nk <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      rsp_done <= 1'b0;
      rsp_err <= 1'b0;
      cnt <= cnt + CW'(1);
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            fn_q <= req_field_num;
            dst_q <= req_dst_addr;
            nv <= '0;
            nk <= '0;
            cnt <= '0;
            if (!is_varint_type(req_field_type) || req_field_num == '0) begin
              err_q <= 1'b1;
              state <= RESP;
            end else begin
              err_q <= 1'b0;
              state <= VAL_RUN;
              vi_en <= 1'b1;
              vi_dst_addr <= req_dst_addr;
              vi_value <= req_value;
              vi_field_type <= req_field_type;
            end
          end
        end
        VAL_RUN: begin
          if (vi_done) begin
            nv <= vi_bytes_written;
            vi_en <= 1'b0;
            vi_dst_addr <= dst_q - 64'(vi_bytes_written);
            state <= GAP;
          end else if (timeout) begin
            vi_en <= 1'b0;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        GAP: begin
          vi_en <= 1'b1;
          vi_value <= 64'({fn_q, WIRE_VARINT});
          vi_field_type <= KEY_FIELD_TYPE;
          cnt <= '0;
          state <= KEY_RUN;
        end
        KEY_RUN: begin
          if (vi_done) begin
            nk <= vi_bytes_written;
            vi_en <= 1'b0;
            state <= RESP;
          end else if (timeout) begin
            vi_en <= 1'b0;
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          rsp_done <= 1'b1;
          rsp_err <= err_q;
          rsp_bytes <= sum;
          rsp_next_addr <= dst_q - 64'(sum);
          vi_en <= 1'b0;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_field_key_sequencer.sv
// tb_field_key_sequencer: randomized and directed checks of field_key_sequencer against a behavioural varint partner and reference model
module tb_field_key_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [28:0] req_field_num = '0;
  logic [4:0] req_field_type = '0;
  logic [63:0] req_value = '0;
  logic [63:0] req_dst_addr = '0;
  logic rsp_done, rsp_err;
  logic [4:0] rsp_bytes;
  logic [63:0] rsp_next_addr;
  logic vi_en;
  logic [63:0] vi_dst_addr, vi_value;
  logic [4:0] vi_field_type;
  logic vi_done = 1'b0;
  logic [3:0] vi_bytes_written = '0;
  int errors = 0;
  int checks = 0;
  bit stall = 0;
  bit stall_key = 0;
  logic [63:0] q_addr[$], q_val[$];
  logic [4:0] q_type[$];
  always #5 clk = ~clk;
  field_key_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_field_num(req_field_num), .req_field_type(req_field_type),
    .req_value(req_value), .req_dst_addr(req_dst_addr),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_bytes(rsp_bytes), .rsp_next_addr(rsp_next_addr),
    .vi_en(vi_en), .vi_dst_addr(vi_dst_addr), .vi_value(vi_value), .vi_field_type(vi_field_type),
    .vi_done(vi_done), .vi_bytes_written(vi_bytes_written)
  );
  function automatic logic [63:0] enc(input logic [63:0] v, input logic [4:0] t);
    logic [31:0] w;
    w = v[31:0];
    case (t)
      5'd5, 5'd14: return {{32{w[31]}}, w};
      5'd13: return {32'b0, w};
      5'd8: return 64'(v != 0);
      5'd17: return {32'b0, (w << 1) ^ {32{w[31]}}};
      5'd18: return (v << 1) ^ {64{v[63]}};
      default: return v;
    endcase
  endfunction
  function automatic int vlen(input logic [63:0] x);
    int n = 1;
    while (x >= 64'd128) begin
      x = x >> 7;
      n++;
    end
    return n;
  endfunction
  function automatic bit supp(input logic [4:0] t);
    return t inside {5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18};
  endfunction
  int p_cnt = 0, p_lat = 1;
  bit p_served = 0;
  always @(posedge clk) begin
    vi_done <= 1'b0;
    if (!vi_en || stall || (stall_key && vi_field_type == 5'd13)) begin
      p_cnt = 0;
      p_served = 0;
    end else if (!p_served) begin
      if (p_cnt == 0) begin
        p_lat = $urandom_range(1, 4);
        q_addr.push_back(vi_dst_addr);
        q_val.push_back(vi_value);
        q_type.push_back(vi_field_type);
      end
      p_cnt++;
      if (p_cnt >= p_lat) begin
        vi_done <= 1'b1;
        vi_bytes_written <= 4'(vlen(enc(vi_value, vi_field_type)));
        p_served = 1;
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic clear_q();
    q_addr.delete();
    q_val.delete();
    q_type.delete();
  endtask
  task automatic drive_req(input logic [28:0] fn, input logic [4:0] ft, input logic [63:0] val, input logic [63:0] dst);
    int i = 0;
    while (!req_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_field_num = fn;
    req_field_type = ft;
    req_value = val;
    req_dst_addr = dst;
  endtask
  task automatic wait_rsp(inout int lat, output int en_cnt, output bit done);
    done = 0;
    en_cnt = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (rsp_done) done = 1;
      else begin
        en_cnt += int'(vi_en);
        @(negedge clk);
        lat++;
      end
    end
  endtask
  task automatic check_rsp(input logic [28:0] fn, input logic [4:0] ft, input logic [63:0] val,
                           input logic [63:0] dst, input int lat, input int en_cnt, input bit done);
    bit ok;
    int nv, nk;
    ok = supp(ft) && fn != 0;
    nv = ok ? vlen(enc(val, ft)) : 0;
    nk = ok ? vlen({32'b0, fn, 3'b000}) : 0;
    chk("rsp_done", 64'(done), 64'd1);
    chk("rsp_err", 64'(rsp_err), 64'(!ok));
    chk("rsp_bytes", 64'(rsp_bytes), 64'(nv + nk));
    chk("rsp_next_addr", rsp_next_addr, dst - 64'(nv + nk));
    chk("vi_en_at_done", 64'(vi_en), 64'd0);
    chk("phases", 64'(q_addr.size()), ok ? 64'd2 : 64'd0);
    if (!ok) begin
      chk("err_latency", 64'(lat), 64'd2);
      chk("err_no_vi_en", 64'(en_cnt), 64'd0);
    end else if (q_addr.size() == 2) begin
      chk("val_addr", q_addr[0], dst);
      chk("val_value", q_val[0], val);
      chk("val_type", 64'(q_type[0]), 64'(ft));
      chk("key_addr", q_addr[1], dst - 64'(nv));
      chk("key_value", q_val[1], {32'b0, fn, 3'b000});
      chk("key_type", 64'(q_type[1]), 64'd13);
    end
    clear_q();
  endtask
  task automatic field(input logic [28:0] fn, input logic [4:0] ft, input logic [63:0] val, input logic [63:0] dst);
    int lat, en_cnt;
    bit done;
    clear_q();
    drive_req(fn, ft, val, dst);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    wait_rsp(lat, en_cnt, done);
    check_rsp(fn, ft, val, dst, lat, en_cnt, done);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [4:0] types[10] = '{5'd3, 5'd4, 5'd5, 5'd8, 5'd13, 5'd14, 5'd17, 5'd18, 5'd9, 5'd0};
    int lat, en_cnt, seen;
    bit done;
    logic [28:0] fn;
    logic [63:0] v;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {req_ready, rsp_done, rsp_err, rsp_bytes, vi_en, vi_field_type},
        '0);
    chk("reset_addr", rsp_next_addr | vi_dst_addr | vi_value, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);
    field(29'd1, 5'd4, 64'd150, 64'h1000);
    field(29'd16, 5'd13, 64'd1, 64'h200);
    field(29'd2, 5'd17, 64'hFFFF_FFFF, 64'h3000);
    field(29'd5, 5'd9, 64'd7, 64'h4000);
    field(29'd0, 5'd4, 64'd7, 64'h4100);
    field(29'h1FFF_FFFF, 5'd18, 64'h8000_0000_0000_0000, 64'h9000);
    field(29'd3, 5'd5, 64'h8000_0000, 64'd1);
    field(29'd4, 5'd8, 64'd42, 64'h500);
    clear_q();
    stall = 1;
    drive_req(29'd11, 5'd4, 64'd5, 64'h40);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    wait_rsp(lat, en_cnt, done);
    chk("to_done", 64'(done), 64'd1);
    chk("to_err", 64'(rsp_err), 64'd1);
    chk("to_bytes", 64'(rsp_bytes), 64'd0);
    chk("to_next", rsp_next_addr, 64'h40);
    chk("to_en_cycles", 64'(en_cnt), 64'd16);
    chk("to_en_low", 64'(vi_en), 64'd0);
    stall = 0;
    clear_q();
    stall_key = 1;
    drive_req(29'd7, 5'd4, 64'd300, 64'h5000);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      if (vi_en && vi_field_type == 5'd13) seen = 1;
      else @(negedge clk);
    end
    chk("reached_key_run", 64'(seen), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {req_ready, rsp_done, rsp_err, rsp_bytes, vi_en, vi_field_type}, '0);
    chk("mid_reset_addr", rsp_next_addr | vi_dst_addr | vi_value, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stall_key = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen += int'(rsp_done);
    end
    chk("no_done_after_reset", 64'(seen), 64'd0);
    field(29'd7, 5'd4, 64'd300, 64'h5000);
    clear_q();
    drive_req(29'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FF85, 64'h8000);
    @(negedge clk);
    req_field_num = 29'd9;
    req_field_type = 5'd18;
    req_value = 64'hFFFF_FFFF_FFFF_FFFB;
    req_dst_addr = 64'h100;
    lat = 1;
    wait_rsp(lat, en_cnt, done);
    chk("b2b_ready", 64'(req_ready), 64'd1);
    check_rsp(29'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FF85, 64'h8000, lat, en_cnt, done);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    wait_rsp(lat, en_cnt, done);
    check_rsp(29'd9, 5'd18, 64'hFFFF_FFFF_FFFF_FFFB, 64'h100, lat, en_cnt, done);
    for (int k = 0; k < 25; k++) begin
      fn = ($urandom_range(0, 5) == 0) ? 29'($urandom_range(0, 20)) : 29'($urandom);
      v = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) v = v >> $urandom_range(0, 63);
      field(fn, types[$urandom_range(0, 9)], v, {32'($urandom), 32'($urandom)});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/field_key_sequencer.md
Name: field_key_sequencer

Overview:
Upstream controller for the varint serializer stage. It takes one scalar field descriptor (field number, field type, value, destination address) and drives the varint stage twice: first for the value, then for the protobuf key (field_number<<3 | wire_type). Output is written backwards in memory, so the key lands immediately below the value. It returns the total bytes written and the next free (lower) address to the message-level walker.

Parameters:
TIMEOUT_CYCLES, 127, maximum cycles to wait for vi_done in either phase before aborting with an error.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  field request present
req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready
req_field_num  in  29  protobuf field number
req_field_type  in  5  descriptor field type code (same encoding as the varint stage)
req_value  in  64  raw field value
req_dst_addr  in  64  highest byte address for this field
rsp_done  out  1  one-cycle completion pulse
rsp_err  out  1  valid with rsp_done; 1 = field not serialized
rsp_bytes  out  5  total bytes written (value + key, max 15); valid with rsp_done
rsp_next_addr  out  64  req_dst_addr - rsp_bytes; valid with rsp_done
vi_en  out  1  enable to varint stage; held high for a whole phase
vi_dst_addr  out  64  destination address for the current phase
vi_value  out  64  value for the current phase
vi_field_type  out  5  field type for the current phase
vi_done  in  1  varint stage completion pulse
vi_bytes_written  in  4  varint stage byte count; sampled in the cycle vi_done is high

Behaviour:
- Reset is asynchronous and active-high. All outputs go to 0 and state goes to IDLE. A reset mid-operation abandons the field and produces no rsp_done.
- States:
  - IDLE: req_ready=1. On accept, latch all req_* fields.
    - Supported types are 3, 4, 5, 8, 13, 14, 17, 18. An unsupported type or field_num==0 goes to RESP with err=1, bytes=0.
    - Otherwise go to VAL_RUN.
  - VAL_RUN: vi_en=1, vi_dst_addr=latched dst, vi_value=latched value, vi_field_type=latched type.
    - On vi_done: latch nv=vi_bytes_written, then go to GAP.
  - GAP: exactly one cycle with vi_en=0. This clears the varint stage's byte count.
    - vi_dst_addr is updated to dst - nv; then go to KEY_RUN.
  - KEY_RUN: vi_en=1, vi_value = zero-extended {field_num, 3'b000}, vi_field_type=KEY_FIELD_TYPE (13).
    - On vi_done: latch nk=vi_bytes_written, then go to RESP.
  - RESP: one cycle.
    - rsp_done=1, rsp_bytes=nv+nk, rsp_next_addr=dst-(nv+nk), rsp_err as latched.
    - Return to IDLE, with vi_en=0 in that same cycle.
- Wire type is 0 for every supported type, so key = field_num<<3.
- Timeout: a phase counter clears on entry to VAL_RUN and KEY_RUN and increments each cycle.
  - Reaching TIMEOUT_CYCLES goes to RESP with err=1, bytes = bytes already latched, vi_en dropped.
- vi_done outside VAL_RUN/KEY_RUN is ignored.
- Address arithmetic is modulo 2^64. Wrap below 0 is not flagged.
- rsp_bytes/rsp_next_addr hold their value until the next rsp_done. rsp_done and rsp_err are pulses.
- Back-to-back requests: at least 1 idle cycle (IDLE) between fields, so vi_en is low for at least 1 cycle between fields.

Decomposition:
- Package fks_pkg:
  - state enum {IDLE, VAL_RUN, GAP, KEY_RUN, RESP}
  - field type constants (TYPE_INT64=3 … TYPE_SINT64=18)
  - KEY_FIELD_TYPE=13
  - WIRE_VARINT=0
  - function is_varint_type()
- No sub-module; the FSM, counter and latches live in one module.
- The bench instantiates this block with the existing varint stage as the vi_* partner.

Test Plan:
- field 1, type 4, value 150, dst 0x1000
  - -> VAL phase writes 2 bytes, key 0x08 written at 0x0FFE
  - -> rsp_bytes=3, rsp_next_addr=0x0FFD, err=0
- field 16, type 13, value 1, dst 0x200
  - -> value 1 byte, key 128 encodes as 2 bytes
  - -> rsp_bytes=3, next_addr=0x1FD
- field 2, type 17, value 0xFFFFFFFF (-1)
  - -> zigzag 1, 1 byte, key 0x10
  - -> rsp_bytes=2
- field 5, type 9 (string)
  - -> vi_en never asserted
  - -> rsp_done 2 cycles after accept, err=1, bytes=0, next_addr=dst
- vi_done tied low, TIMEOUT_CYCLES=16
  - -> rsp_err=1 after 16 cycles in VAL_RUN, bytes=0, vi_en low next cycle
- reset asserted during KEY_RUN
  - -> all outputs 0 immediately, no rsp_done
  - -> a new request accepted after release completes normally
- Two consecutive requests with req_valid held high
  - -> vi_en low for at least 1 cycle between fields
  - -> both rsp_done pulses carry correct counts
